// File: rtl/multicycle_sequencer_if.sv
// Shared instruction/data memory port handshake between the sequencer and memory.
// The sequencer acts as master and holds mem_req until memory answers with mem_ready.
interface multicycle_sequencer_if;
    logic mem_req;
    logic mem_we;
    logic mem_dsel;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output mem_dsel, input mem_ready);
    modport slave  (input mem_req, input mem_we, input mem_dsel, output mem_ready);
endinterface

// File: rtl/multicycle_sequencer.sv
// Multicycle control FSM: walks each instruction through FETCH/DECODE/EXEC/MEM/WB,
// drives datapath strobes, counts retired instructions and halts on the stop bit.
module multicycle_sequencer #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             ins_type,
    input  logic [4:0]             func,
    input  logic                   stop,
    input  logic                   zero,
    multicycle_sequencer_if.master memIf,
    output logic [2:0]             state,
    output logic                   ir_we,
    output logic                   alu_en,
    output logic                   rf_we,
    output logic [1:0]             wb_sel,
    output logic                   pc_we,
    output logic [1:0]             pc_src,
    output logic                   halted,
    output logic                   err,
    output logic [CNT_W-1:0]       instr_cnt
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6
    } seqState_t;

    seqState_t        stateR, nextStateS, retireNextS;
    logic [1:0]       typeR;
    logic [4:0]       funcR;
    logic             stopR;
    logic [7:0]       waitCntR;
    logic             errR;
    logic [CNT_W-1:0] instrCntR;

    logic isLoadS, isStoreS, isBranchS, isJumpS, toWbS;
    logic waitingS, timeoutS, retireS;
    logic memReqS, memWeS, memDselS, irWeS, aluEnS, rfWeS, pcWeS;
    logic [1:0] wbSelS, pcSrcS;

    assign isLoadS     = (typeR == 2'b01) && (funcR == 5'b00010);
    assign isStoreS    = (typeR == 2'b01) && (funcR == 5'b00011);
    assign isBranchS   = (typeR == 2'b01) && (funcR == 5'b00100);
    assign isJumpS     = (typeR == 2'b10);
    assign waitingS    = ((stateR == FETCH) || (stateR == MEM)) && !memIf.mem_ready;
    // A ready response in the same cycle always beats the timeout.
    assign timeoutS    = waitingS && (waitCntR == 8'(TIMEOUT - 1));
    assign retireNextS = stopR ? HALT : FETCH;

    // Instruction classes that finish by writing the ALU result back.
    always_comb begin
        toWbS = 1'b0;
        case (typeR)
            2'b00:   toWbS = (funcR != 5'b00011);
            2'b01:   toWbS = (funcR <= 5'b00001);
            2'b11:   toWbS = 1'b1;
            default: toWbS = 1'b0;
        endcase
    end

    // Next-state and per-cycle strobe decode.
    always_comb begin
        nextStateS = stateR;
        memReqS    = 1'b0;
        memWeS     = 1'b0;
        memDselS   = 1'b0;
        irWeS      = 1'b0;
        aluEnS     = 1'b0;
        rfWeS      = 1'b0;
        wbSelS     = 2'b00;
        pcWeS      = 1'b0;
        pcSrcS     = 2'b00;
        retireS    = 1'b0;
        case (stateR)
            IDLE: nextStateS = FETCH;
            FETCH: begin
                memReqS = 1'b1;
                if (memIf.mem_ready) begin
                    irWeS      = 1'b1;
                    nextStateS = DECODE;
                end else if (timeoutS) begin
                    nextStateS = HALT;
                end else begin
                    nextStateS = FETCH;
                end
            end
            DECODE: nextStateS = EXEC;
            EXEC: begin
                aluEnS = 1'b1;
                if (isLoadS || isStoreS) begin
                    nextStateS = MEM;
                end else if (toWbS) begin
                    nextStateS = WB;
                end else begin
                    retireS    = 1'b1;
                    pcWeS      = 1'b1;
                    nextStateS = retireNextS;
                    if (isJumpS) begin
                        pcSrcS = 2'b10;
                        rfWeS  = (funcR != 5'b00000);
                        wbSelS = (funcR != 5'b00000) ? 2'b10 : 2'b00;
                    end else if (isBranchS) begin
                        pcSrcS = zero ? 2'b01 : 2'b00;
                    end else begin
                        pcSrcS = 2'b00;
                    end
                end
            end
            MEM: begin
                memReqS  = 1'b1;
                memDselS = 1'b1;
                memWeS   = isStoreS;
                if (memIf.mem_ready) begin
                    if (isStoreS) begin
                        retireS    = 1'b1;
                        pcWeS      = 1'b1;
                        nextStateS = retireNextS;
                    end else begin
                        nextStateS = WB;
                    end
                end else if (timeoutS) begin
                    nextStateS = HALT;
                end else begin
                    nextStateS = MEM;
                end
            end
            WB: begin
                rfWeS      = 1'b1;
                wbSelS     = isLoadS ? 2'b01 : 2'b00;
                pcWeS      = 1'b1;
                retireS    = 1'b1;
                nextStateS = retireNextS;
            end
            HALT:    nextStateS = HALT;
            default: nextStateS = IDLE;
        endcase
    end

    // State, wait counter, sticky error, retire counter and latched IR fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateR    <= IDLE;
            waitCntR  <= 8'd0;
            errR      <= 1'b0;
            instrCntR <= '0;
            typeR     <= 2'b00;
            funcR     <= 5'b00000;
            stopR     <= 1'b0;
        end else begin
            stateR <= nextStateS;
            if (nextStateS != stateR) begin
                waitCntR <= 8'd0;
            end else if (waitingS) begin
                waitCntR <= waitCntR + 8'd1;
            end
            if (timeoutS) begin
                errR <= 1'b1;
            end
            if (retireS) begin
                instrCntR <= instrCntR + CNT_W'(1'b1);
            end
            if (stateR == DECODE) begin
                typeR <= ins_type;
                funcR <= func;
                stopR <= stop;
            end
        end
    end

    assign memIf.mem_req  = memReqS;
    assign memIf.mem_we   = memWeS;
    assign memIf.mem_dsel = memDselS;
    assign state          = stateR;
    assign ir_we          = irWeS;
    assign alu_en         = aluEnS;
    assign rf_we          = rfWeS;
    assign wb_sel         = wbSelS;
    assign pc_we          = pcWeS;
    assign pc_src         = pcSrcS;
    assign halted         = (stateR == HALT);
    assign err            = errR;
    assign instr_cnt      = instrCntR;
endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: walks instruction classes, memory stalls,
// halt, timeout and mid-access reset with hand-computed per-cycle strobe words.
module tb_multicycle_sequencer;
    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
                           S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6;

    logic        clk;
    logic        rst_n;
    logic [1:0]  ins_type;
    logic [4:0]  func;
    logic        stop;
    logic        zero;
    logic [2:0]  state;
    logic        ir_we, alu_en, rf_we, pc_we, halted, err;
    logic [1:0]  wb_sel, pc_src;
    logic [15:0] instr_cnt;
    logic [15:0] obsWord;
    int          totalCnt;
    int          badCnt;

    multicycle_sequencer_if memBus();

    multicycle_sequencer #(.CNT_W(16), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .ins_type(ins_type), .func(func), .stop(stop),
        .zero(zero), .memIf(memBus), .state(state), .ir_we(ir_we), .alu_en(alu_en),
        .rf_we(rf_we), .wb_sel(wb_sel), .pc_we(pc_we), .pc_src(pc_src),
        .halted(halted), .err(err), .instr_cnt(instr_cnt)
    );

    assign obsWord = {state, memBus.mem_req, memBus.mem_we, memBus.mem_dsel, ir_we, alu_en,
                      rf_we, wb_sel, pc_we, pc_src, halted, err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] pk(input logic [2:0] st, input logic req, input logic we,
                                       input logic dsel, input logic irWe, input logic alu,
                                       input logic rfWe, input logic [1:0] wbSel,
                                       input logic pcWe, input logic [1:0] pcSrc,
                                       input logic hlt, input logic er);
        return {st, req, we, dsel, irWe, alu, rfWe, wbSel, pcWe, pcSrc, hlt, er};
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCnt++;
        if (obs !== exp) begin
            badCnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic expectWord(input string tag, input logic [15:0] e);
        #1;
        checkVal(tag, {16'h0000, obsWord}, {16'h0000, e});
    endtask

    task automatic expectCnt(input string tag, input logic [15:0] e);
        #1;
        checkVal(tag, {16'h0000, instr_cnt}, {16'h0000, e});
    endtask

    task automatic setIr(input logic [1:0] t, input logic [4:0] f, input logic s);
        ins_type = t;
        func     = f;
        stop     = s;
    endtask

    logic [15:0] wIdle, wFetchRdy, wFetchWait, wDecode, wExecAlu, wWbAlu, wWbMem;
    logic [15:0] wMemRd, wMemWr, wHalt, wHaltErr;

    // Expects FETCH with zero-wait memory and then DECODE; leaves the bench in EXEC.
    task automatic fetchDecode(input string tag);
        expectWord({tag, "_fetch"}, wFetchRdy);
        tick();
        expectWord({tag, "_decode"}, wDecode);
        tick();
    endtask

    initial begin
        totalCnt = 0;
        badCnt   = 0;
        wIdle      = pk(S_IDLE,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0);
        wFetchRdy  = pk(S_FETCH,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0);
        wFetchWait = pk(S_FETCH,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0);
        wDecode    = pk(S_DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0);
        wExecAlu   = pk(S_EXEC,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0);
        wWbAlu     = pk(S_WB,     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0);
        wWbMem     = pk(S_WB,     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 2'b00, 1'b0, 1'b0);
        wMemRd     = pk(S_MEM,    1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0);
        wMemWr     = pk(S_MEM,    1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0);
        wHalt      = pk(S_HALT,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0);
        wHaltErr   = pk(S_HALT,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b1);

        rst_n = 1'b0;
        zero  = 1'b0;
        memBus.mem_ready = 1'b1;
        setIr(2'b00, 5'b00000, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;

        // R add, zero-wait memory.
        expectWord("rst_idle", wIdle);
        expectCnt("rst_cnt", 16'd0);
        tick();
        fetchDecode("radd");
        expectWord("radd_exec", wExecAlu);
        tick();
        expectWord("radd_wb", wWbAlu);
        tick();
        expectCnt("radd_cnt", 16'd1);

        // Load with three stalled MEM cycles; the fourth arrives exactly at the timeout edge.
        setIr(2'b01, 5'b00010, 1'b0);
        fetchDecode("load");
        expectWord("load_exec", wExecAlu);
        tick();
        memBus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expectWord("load_mem_wait", wMemRd);
            tick();
        end
        memBus.mem_ready = 1'b1;
        expectWord("load_mem_rdy", wMemRd);
        tick();
        expectWord("load_wb", wWbMem);
        tick();
        expectCnt("load_cnt", 16'd2);

        // Branch taken, then not taken.
        setIr(2'b01, 5'b00100, 1'b0);
        zero = 1'b1;
        fetchDecode("beq_t");
        expectWord("beq_t_exec", pk(S_EXEC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 2'b01, 1'b0, 1'b0));
        tick();
        zero = 1'b0;
        fetchDecode("beq_n");
        expectWord("beq_n_exec", pk(S_EXEC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0));
        tick();
        expectCnt("beq_cnt", 16'd4);

        // jal links, plain j does not.
        setIr(2'b10, 5'b00001, 1'b0);
        fetchDecode("jal");
        expectWord("jal_exec", pk(S_EXEC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 1'b1, 2'b10, 1'b0, 1'b0));
        tick();
        setIr(2'b10, 5'b00000, 1'b0);
        fetchDecode("j");
        expectWord("j_exec", pk(S_EXEC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 2'b10, 1'b0, 1'b0));
        tick();

        // Compare retires in EXEC without write-back.
        setIr(2'b00, 5'b00011, 1'b0);
        fetchDecode("cmp");
        expectWord("cmp_exec", pk(S_EXEC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0));
        tick();
        expectCnt("cmp_cnt", 16'd7);

        // Store with stop: retire in MEM, then HALT ignores memory and freezes the count.
        setIr(2'b01, 5'b00011, 1'b1);
        fetchDecode("st");
        expectWord("st_exec", wExecAlu);
        tick();
        expectWord("st_mem", wMemWr);
        tick();
        for (int i = 0; i < 20; i++) begin
            memBus.mem_ready = (i % 2 == 0) ? 1'b0 : 1'b1;
            expectWord("halt_word", wHalt);
            expectCnt("halt_cnt", 16'd8);
            tick();
        end

        // Reset out of HALT, then a FETCH that never completes times out after 4 waits.
        rst_n = 1'b0;
        expectWord("rst_halt_idle", wIdle);
        tick();
        rst_n = 1'b1;
        memBus.mem_ready = 1'b0;
        setIr(2'b00, 5'b00000, 1'b0);
        expectWord("to_idle", wIdle);
        tick();
        for (int i = 0; i < 4; i++) begin
            expectWord("to_fetch_wait", wFetchWait);
            tick();
        end
        expectWord("to_halt_err", wHaltErr);
        expectCnt("to_cnt", 16'd0);
        tick();
        expectWord("to_halt_hold", wHaltErr);

        // Reset mid-MEM after one retired instruction.
        rst_n = 1'b0;
        expectWord("rst2_idle", wIdle);
        tick();
        rst_n = 1'b1;
        memBus.mem_ready = 1'b1;
        tick();
        fetchDecode("radd2");
        expectWord("radd2_exec", wExecAlu);
        tick();
        expectWord("radd2_wb", wWbAlu);
        tick();
        expectCnt("radd2_cnt", 16'd1);
        setIr(2'b01, 5'b00010, 1'b0);
        fetchDecode("ld2");
        tick();
        memBus.mem_ready = 1'b0;
        expectWord("ld2_mem", wMemRd);
        tick();
        expectWord("ld2_mem_wait", wMemRd);
        rst_n = 1'b0;
        expectWord("midmem_idle", wIdle);
        expectCnt("midmem_cnt", 16'd0);
        tick();
        expectWord("midmem_hold", wIdle);
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
        $finish;
    end
endmodule
